// File: rtl/food_place_ctrl.sv
// Apple placement controller: draws LFSR candidates, rejects stone cells, the head
// and any body segment, then commits the first free cell. Also flags head-on-stone.
module food_place_ctrl #(
  parameter int MAX_TRIES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] level,
  input  logic       eat_pulse,
  input  logic [5:0] head_x,
  input  logic [4:0] head_y,
  input  logic [5:0] body_len,
  output logic [5:0] body_rd_idx,
  input  logic [5:0] body_rd_x,
  input  logic [4:0] body_rd_y,
  output logic [5:0] apple_x,
  output logic [4:0] apple_y,
  output logic       apple_valid,
  output logic       busy,
  output logic       place_done,
  output logic       place_fail,
  output logic       head_on_stone
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_STONE,
    S_BODY,
    S_COMMIT
  } state_t;

  function automatic logic [5:0] map_x(input logic [10:0] r);
    logic [5:0] x;
    x = r[10:5];
    if (x > 6'd38) x = x - 6'd25;
    if (x == 6'd0) x = 6'd1;
    return x;
  endfunction

  function automatic logic [4:0] map_y(input logic [10:0] r);
    logic [4:0] y;
    y = r[4:0];
    if (y > 5'd28) y = y - 5'd3;
    if (y == 5'd0) y = 5'd1;
    return y;
  endfunction

  // Level 3 has no map and behaves like level 0.
  function automatic logic is_stone(input logic [1:0] lvl, input logic [5:0] x,
                                    input logic [4:0] y);
    logic hit_a;
    logic hit_b;
    logic hit;
    hit_a = ((x == 6'd4 || x == 6'd35) && y >= 5'd10 && y <= 5'd19)
         || (y == 5'd5  && x >= 6'd15 && x <= 6'd29)
         || (y == 5'd24 && x >= 6'd10 && x <= 6'd29);
    hit_b = ((x == 6'd4 || x == 6'd20 || x == 6'd35) && y >= 5'd5 && y <= 5'd24)
         || (y == 5'd5 && x >= 6'd15 && x <= 6'd29)
         || ((y == 5'd24 || y == 5'd15) && x >= 6'd10 && x <= 6'd29);
    case (lvl)
      2'd1:    hit = hit_a;
      2'd2:    hit = hit_b;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  state_t           state_q, state_d;
  logic [10:0]      lfsr_q, lfsr_d;
  logic [5:0]       cand_x_q, cand_x_d;
  logic [4:0]       cand_y_q, cand_y_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [5:0]       rd_idx_q, rd_idx_d;
  logic             chk_vld_q, chk_vld_d;
  logic             chk_last_q, chk_last_d;
  logic [5:0]       apple_x_q, apple_x_d;
  logic [4:0]       apple_y_q, apple_y_d;
  logic             apple_valid_q, apple_valid_d;
  logic             place_done_q, place_done_d;
  logic             place_fail_q, place_fail_d;
  logic             hos_q, hos_d;
  logic [1:0]       level_q, level_d;

  logic             retry;
  logic             abort;
  logic             cand_blocked;
  logic             body_hit;
  logic [5:0]       last_idx;

  assign lfsr_d   = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
  assign hos_d    = is_stone(level, head_x, head_y);
  assign level_d  = level;

  // A level change while busy invalidates the candidate against the old map.
  assign abort        = (state_q != S_IDLE) && (level != level_q);
  assign cand_blocked = is_stone(level, cand_x_q, cand_y_q)
                     || (cand_x_q == head_x && cand_y_q == head_y);
  assign body_hit     = chk_vld_q && (body_rd_x == cand_x_q) && (body_rd_y == cand_y_q);
  assign last_idx     = body_len - 6'd1;

  always_comb begin
    state_d       = state_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    tries_d       = tries_q;
    rd_idx_d      = rd_idx_q;
    chk_vld_d     = chk_vld_q;
    chk_last_d    = chk_last_q;
    apple_x_d     = apple_x_q;
    apple_y_d     = apple_y_q;
    apple_valid_d = apple_valid_q;
    place_done_d  = 1'b0;
    place_fail_d  = 1'b0;
    retry         = 1'b0;

    if (abort) begin
      state_d = S_DRAW;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (eat_pulse) begin
            state_d       = S_DRAW;
            apple_valid_d = 1'b0;
            tries_d       = '0;
          end
        end
        S_DRAW: begin
          cand_x_d = map_x(lfsr_q);
          cand_y_d = map_y(lfsr_q);
          state_d  = S_STONE;
        end
        S_STONE: begin
          if (cand_blocked) begin
            retry = 1'b1;
          end else if (body_len == 6'd0) begin
            state_d = S_COMMIT;
          end else begin
            state_d    = S_BODY;
            rd_idx_d   = 6'd0;
            chk_vld_d  = 1'b0;
            chk_last_d = 1'b0;
          end
        end
        S_BODY: begin
          // Read data lags the address by a cycle, so the scan is body_len+1 cycles.
          if (body_hit) begin
            retry = 1'b1;
          end else if (chk_vld_q && chk_last_q) begin
            state_d = S_COMMIT;
          end else begin
            chk_vld_d  = 1'b1;
            chk_last_d = (rd_idx_q == last_idx);
            if (rd_idx_q != last_idx) rd_idx_d = rd_idx_q + 6'd1;
          end
        end
        S_COMMIT: begin
          apple_x_d     = cand_x_q;
          apple_y_d     = cand_y_q;
          apple_valid_d = 1'b1;
          place_done_d  = 1'b1;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (retry) begin
      state_d = S_DRAW;
      if (tries_q == TRY_LAST) begin
        tries_d      = '0;
        place_fail_d = 1'b1;
      end else begin
        tries_d = tries_q + TRY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 11'd1;
      tries_q       <= '0;
      rd_idx_q      <= 6'd0;
      chk_vld_q     <= 1'b0;
      chk_last_q    <= 1'b0;
      apple_x_q     <= 6'd20;
      apple_y_q     <= 5'd10;
      apple_valid_q <= 1'b1;
      place_done_q  <= 1'b0;
      place_fail_q  <= 1'b0;
      hos_q         <= 1'b0;
      level_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      tries_q       <= tries_d;
      rd_idx_q      <= rd_idx_d;
      chk_vld_q     <= chk_vld_d;
      chk_last_q    <= chk_last_d;
      apple_x_q     <= apple_x_d;
      apple_y_q     <= apple_y_d;
      apple_valid_q <= apple_valid_d;
      place_done_q  <= place_done_d;
      place_fail_q  <= place_fail_d;
      hos_q         <= hos_d;
      level_q       <= level_d;
    end
  end

  // Candidate is pure data, always rewritten in DRAW before it is used.
  always_ff @(posedge clk) begin
    cand_x_q <= cand_x_d;
    cand_y_q <= cand_y_d;
  end

  assign body_rd_idx   = rd_idx_q;
  assign apple_x       = apple_x_q;
  assign apple_y       = apple_y_q;
  assign apple_valid   = apple_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign place_done    = place_done_q;
  assign place_fail    = place_fail_q;
  assign head_on_stone = hos_q;

endmodule

// File: doc/food_place_ctrl.md
FOOD_PLACE_CTRL -- requirements
Module: food_place_ctrl

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 16, which sets the number of rejected candidates before place_fail pulses.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port level, input, 2, obstacle map select: 0 none, 1 map A, 2 map B, 3 treated as 0.
REQ-005 SHALL have port eat_pulse, input, 1, one-cycle request to place a new apple.
REQ-006 SHALL have ports head_x (input, 6) and head_y (input, 5), giving the current snake head cell.
REQ-007 SHALL have port body_len, input, 6, number of body segments to check (0..63).
REQ-008 SHALL have port body_rd_idx, output, 6, body memory read address.
REQ-009 SHALL have ports body_rd_x (input, 6) and body_rd_y (input, 5), carrying segment data one cycle after body_rd_idx.
REQ-010 SHALL have ports apple_x (output, 6) and apple_y (output, 5), the committed apple cell.
REQ-011 SHALL have port apple_valid, output, 1, high when the apple position is committed and displayable.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have ports place_done and place_fail, outputs, 1 each, one-cycle status pulses.
REQ-014 SHALL have port head_on_stone, output, 1, registered flag that the head is on a stone cell of the current map.

Function
REQ-015 SHALL run an 11-bit LFSR r every cycle: seed 1, next value {r[9:0], r[10]^r[8]}.
REQ-016 SHALL map candidates as follows: cx = r[10:5]; if cx>38 then cx-25; if cx==0 then 1. cy = r[4:0]; if cy>28 then cy-3; if cy==0 then 1.
REQ-017 SHALL define the map A stone cells as: x=4, y10..19; x=35, y10..19; y=5, x15..29; y=24, x10..29.
REQ-018 SHALL define the map B stone cells as: x=4, x=20 and x=35, each for y5..24; y=5, x15..29; y=24, x10..29; y=15, x10..29.
REQ-019 SHALL implement the FSM states IDLE, DRAW, STONE, BODY, COMMIT.
REQ-020 SHALL move from IDLE to DRAW when eat_pulse=1; in the same edge apple_valid goes to 0 and the try counter is cleared.
REQ-021 SHALL, in DRAW, latch (cx,cy) from the LFSR and go to STONE (1 cycle).
REQ-022 SHALL, in STONE, return to DRAW with tries+1 if the candidate is a stone cell or equals (head_x,head_y).
REQ-023 SHALL, in STONE when the candidate is accepted, go to BODY with idx=0, or go directly to COMMIT if body_len==0.
REQ-024 SHALL, in BODY, drive body_rd_idx=idx and compare the returned data on the following cycle; a match returns to DRAW with tries+1.
REQ-025 SHALL go from BODY to COMMIT once the comparison for idx=body_len-1 shows no match; scan length is body_len+1 cycles.
REQ-026 SHALL, in COMMIT, load apple_x/apple_y from the candidate, set apple_valid=1, pulse place_done and return to IDLE.
REQ-027 SHALL, when tries reaches MAX_TRIES, pulse place_fail, clear tries and keep drawing; apple_valid stays 0.
REQ-028 SHALL ignore eat_pulse while busy=1, with no queuing.
REQ-029 SHALL abort a placement in progress to DRAW when level changes, without incrementing tries; the map is always evaluated from the current level.
REQ-030 SHALL update head_on_stone every cycle from head_x/head_y and the level map, with 1-cycle latency, in all FSM states.
REQ-031 SHALL produce a best-case placement latency of 4 cycles from eat_pulse to place_done with body_len=0 (IDLE to DRAW, DRAW to STONE, STONE to COMMIT, done).

Reset
REQ-032 SHALL, with rst_n=0, asynchronously force: state IDLE, LFSR=1, apple_x=20, apple_y=10, apple_valid=1, busy=0, place_done=0, place_fail=0, head_on_stone=0, body_rd_idx=0, tries=0.
REQ-033 SHALL discard any placement in progress on reset assertion mid-operation; after release the block resumes in IDLE with the reset apple.

Verification
REQ-034 SHALL cover: reset release, level=0, body_len=0, one eat_pulse -> place_done 4 cycles later with a candidate matching a reference LFSR model, and apple_valid back to 1.
REQ-035 SHALL cover: level=2 with head swept over (20,5..24) -> head_on_stone=1 one cycle later, and 0 at (21,10).
REQ-036 SHALL cover: body_len=3 with one segment equal to the first candidate -> that candidate is rejected, and the committed apple equals no segment, no stone and not the head.
REQ-037 SHALL cover: body memory model forcing every candidate to match (MAX_TRIES=4) -> place_fail pulses after 4 rejections, apple_valid stays 0 and busy stays 1.
REQ-038 SHALL cover: eat_pulse during BODY -> ignored, exactly one place_done; level change from 1 to 2 during BODY -> restart at DRAW, final apple not on a map B stone.
REQ-039 SHALL cover: rst_n pulsed low during STONE -> outputs immediately take reset values and the next eat_pulse places normally.
